// File: rtl/sdp_y_mul_out_pkg.sv
// Shared constants and types for the SDP Y mul-out receive pipe.
package sdp_y_mul_out_pkg;
  localparam int SDP_Y_DW    = 256;  // 16 lanes x 16 bit
  localparam int SDP_Y_CNT_W = 32;

  // Buffer occupancy encoded as {out_pvld, skid_vld}
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  typedef logic [SDP_Y_DW-1:0] payload_t;
endpackage

// File: rtl/sdp_y_mul_out_rcv_pipe_if.sv
// Generic valid/ready payload channel; master drives vld/pd, slave drives rdy.
interface sdp_y_mul_out_rcv_pipe_if
  import sdp_y_mul_out_pkg::*;
#(
  parameter int DW = SDP_Y_DW
);
  logic          vld;
  logic          rdy;
  logic [DW-1:0] pd;

  modport master (output vld, output pd, input  rdy);
  modport slave  (input  vld, input  pd, output rdy);
endinterface

// File: rtl/sdp_y_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sdp_y_sat_counter #(
  parameter int W = 32
)(
  input  logic         nvdla_core_clk,
  input  logic         nvdla_core_rstn,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  // count up on i_inc, stick at all-ones, clear on i_clr
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn)                r_cnt <= '0;
    else if (i_clr)                      r_cnt <= '0;
    else if (i_inc && (r_cnt != '1))     r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/sdp_y_mul_out_rcv_pipe.sv
// Receiver for the chn_mul_out channel: 2-entry registered skid buffer with
// registered ready and registered downstream valid/payload.
// Optional stall counter enabled by `define SDP_Y_MUL_OUT_STALL_CNT_EN.
module sdp_y_mul_out_rcv_pipe
  import sdp_y_mul_out_pkg::*;
#(
  parameter int DW = SDP_Y_DW
`ifdef SDP_Y_MUL_OUT_STALL_CNT_EN
  , parameter int CNT_W = SDP_Y_CNT_W
`endif
)(
  input  logic                              nvdla_core_clk,
  input  logic                              nvdla_core_rstn,
  sdp_y_mul_out_rcv_pipe_if.slave           chn_mul_out,
  sdp_y_mul_out_rcv_pipe_if.master          out
`ifdef SDP_Y_MUL_OUT_STALL_CNT_EN
  , input  logic                            reg2dp_clr_stall
  , output logic [CNT_W-1:0]                dp2reg_stall_cnt
`endif
);
  logic          r_out_pvld;
  logic [DW-1:0] r_out_pd;
  logic          r_skid_vld;
  logic [DW-1:0] r_skid_pd;
  logic          r_rdy;
  logic          w_in_xfer;
  logic          w_out_xfer;

  assign w_in_xfer  = chn_mul_out.vld & r_rdy;
  assign w_out_xfer = r_out_pvld & out.rdy;

  // occupancy state machine; ready is a flop so out.rdy never reaches chn_mul_out.rdy
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_out_pvld <= 1'b0;
      r_out_pd   <= '0;
      r_skid_vld <= 1'b0;
      r_skid_pd  <= '0;
      r_rdy      <= 1'b1;
    end else begin
      case ({r_out_pvld, r_skid_vld})
        ST_EMPTY: begin
          if (w_in_xfer) begin
            r_out_pd   <= chn_mul_out.pd;
            r_out_pvld <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_out_pd <= chn_mul_out.pd;
          end else if (w_in_xfer) begin
            r_skid_pd  <= chn_mul_out.pd;
            r_skid_vld <= 1'b1;
            r_rdy      <= 1'b0;
          end else if (w_out_xfer) begin
            r_out_pvld <= 1'b0;
          end
        end
        ST_FULL: begin
          if (w_out_xfer) begin
            r_out_pd   <= r_skid_pd;
            r_skid_vld <= 1'b0;
            r_rdy      <= 1'b1;
          end
        end
        default: begin
          // unreachable skid-only state: recover to EMPTY
          r_skid_vld <= 1'b0;
          r_rdy      <= 1'b1;
        end
      endcase
    end
  end

  assign chn_mul_out.rdy = r_rdy;
  assign out.vld         = r_out_pvld;
  assign out.pd          = r_out_pd;

`ifdef SDP_Y_MUL_OUT_STALL_CNT_EN
  logic w_stall;
  assign w_stall = r_out_pvld & ~out.rdy;

  sdp_y_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .i_clr           (reg2dp_clr_stall),
    .i_inc           (w_stall),
    .o_cnt           (dp2reg_stall_cnt)
  );
`endif
endmodule

// File: tb/tb_sdp_y_mul_out_rcv_pipe.sv
// Self-checking bench for sdp_y_mul_out_rcv_pipe; the reference is a bounded
// FIFO of capacity 2 (ready = fewer than 2 held, valid = anything held).
module tb_sdp_y_mul_out_rcv_pipe;
  import sdp_y_mul_out_pkg::*;

  localparam int DW = SDP_Y_DW;

  logic clk;
  logic rstn;
  logic clr;
  logic [31:0] cnt;

  int total = 0;
  int bad   = 0;

  payload_t q[$];
  logic [31:0] stall_m;

  sdp_y_mul_out_rcv_pipe_if #(.DW(DW)) chn ();
  sdp_y_mul_out_rcv_pipe_if #(.DW(DW)) out ();

  sdp_y_mul_out_rcv_pipe #(.DW(DW)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .chn_mul_out     (chn.slave),
    .out             (out.master)
`ifdef SDP_Y_MUL_OUT_STALL_CNT_EN
    , .reg2dp_clr_stall (clr)
    , .dp2reg_stall_cnt (cnt)
`endif
  );

`ifdef SDP_Y_MUL_OUT_STALL_CNT_EN
  // narrow-counter instance so saturation is reachable in a short run
  sdp_y_mul_out_rcv_pipe_if #(.DW(DW)) s_chn ();
  sdp_y_mul_out_rcv_pipe_if #(.DW(DW)) s_out ();
  logic       s_clr;
  logic [3:0] s_cnt;
  sdp_y_mul_out_rcv_pipe #(.DW(DW), .CNT_W(4)) dut_sat (
    .nvdla_core_clk   (clk),
    .nvdla_core_rstn  (rstn),
    .chn_mul_out      (s_chn.slave),
    .out              (s_out.master),
    .reg2dp_clr_stall (s_clr),
    .dp2reg_stall_cnt (s_cnt)
  );
`else
  assign cnt = '0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("pvld", out.vld, q.size() > 0);
    chk("rdy",  chn.rdy, q.size() < 2);
    if (q.size() > 0) chk("pd", out.pd, q[0]);
`ifdef SDP_Y_MUL_OUT_STALL_CNT_EN
    chk("stall_cnt", cnt, stall_m);
`endif
  endtask

  // advance one clock: update the reference from pre-edge inputs, then check
  task automatic tick();
    bit in_x, out_x;
    in_x  = chn.vld && (q.size() < 2);
    out_x = (q.size() > 0) && out.rdy;
    if (clr) stall_m = 0;
    else if ((q.size() > 0) && !out.rdy && (stall_m != 32'hFFFF_FFFF)) stall_m++;
    if (out_x) void'(q.pop_front());
    if (in_x)  q.push_back(chn.pd);
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    int nxt, delivered, cyc;
    clk = 0; rstn = 0; clr = 0;
    chn.vld = 0; chn.pd = '0; out.rdy = 0;
`ifdef SDP_Y_MUL_OUT_STALL_CNT_EN
    s_chn.vld = 0; s_chn.pd = '0; s_out.rdy = 0; s_clr = 0;
`endif
    q.delete(); stall_m = 0;

    // reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1;
    chk("rst_pvld", out.vld, 0);
    chk("rst_pd",   out.pd,  0);
    chk("rst_rdy",  chn.rdy, 1);
    chk("rst_cnt",  cnt,     0);

    // streaming at full rate
    out.rdy = 1;
    for (int i = 1; i <= 16; i++) begin
      chn.vld = 1; chn.pd = DW'(i);
      tick();
      chk("stream_pd",  out.pd,  DW'(i));
      chk("stream_rdy", chn.rdy, 1);
    end
    chn.vld = 0;
    tick();
    chk("stream_drain", out.vld, 0);

    // backpressure fills the skid
    out.rdy = 0;
    chn.vld = 1; chn.pd = DW'(32'hA); tick();
    chk("bp_rdy_one", chn.rdy, 1);
    chn.pd = DW'(32'hB); tick();
    chn.vld = 0;
    chk("bp_rdy_full", chn.rdy, 0);
    chk("bp_hold_a",   out.pd,  DW'(32'hA));
    tick();
    chk("bp_hold_a2",  out.pd,  DW'(32'hA));
    out.rdy = 1; tick();
    chk("bp_b",        out.pd,  DW'(32'hB));
    chk("bp_rdy_back", chn.rdy, 1);
    tick();
    chk("bp_empty",    out.vld, 0);

    // random traffic, incrementing payload
    nxt = 1; delivered = 0; cyc = 0;
    while (delivered < 10000 && cyc < 60000) begin
      chn.vld = ($urandom_range(0, 3) != 0);
      chn.pd  = chn.vld ? DW'(nxt) : {8{$urandom}};
      out.rdy = ($urandom_range(0, 3) != 0);
      if (chn.vld && q.size() < 2) nxt++;
      if (q.size() > 0 && out.rdy) delivered++;
      tick();
      cyc++;
    end
    chk("rand_done", delivered >= 10000, 1);
    chn.vld = 0; out.rdy = 1;
    tick(); tick();

    // reset while FULL
    out.rdy = 0;
    chn.vld = 1; chn.pd = DW'(32'h55); tick();
    chn.pd = DW'(32'h66); tick();
    chn.vld = 0;
    chk("mf_full_rdy", chn.rdy, 0);
    #2 rstn = 0;
    #1 chk("mf_async_pvld", out.vld, 0);
    chk("mf_async_rdy", chn.rdy, 1);
    q.delete(); stall_m = 0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
    chk("mf_rel_rdy", chn.rdy, 1);
    out.rdy = 1;
    repeat (3) tick();
    chk("mf_no_stale", out.vld, 0);

`ifdef SDP_Y_MUL_OUT_STALL_CNT_EN
    // stall counting and clear
    out.rdy = 0;
    chn.vld = 1; chn.pd = DW'(32'h7); tick();
    chn.vld = 0;
    repeat (7) tick();
    chk("stall7", cnt, 7);
    clr = 1; tick(); clr = 0;
    chk("stall_clr", cnt, 0);
    out.rdy = 1; tick();

    // saturation on the narrow instance
    s_chn.vld = 1; s_chn.pd = DW'(1);
    @(posedge clk);
    #1 s_chn.vld = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("sat", s_cnt, 4'hF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
